// File: rtl/shift_pkg.sv
// Shared types and constants for the multi-step shift sequencer.
package shift_pkg;

  localparam int DEF_AMT_W = 5;
  localparam int DEF_MAX_STEP = 7;

  typedef enum logic [2:0] {
    OP_LSR = 3'b000,
    OP_ASR = 3'b001,
    OP_LSL = 3'b010,
    OP_ROR = 3'b011,
    OP_ROL = 3'b100
  } op_e;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

  function automatic logic op_legal(
    input logic [2:0] op
  );
    return op <= 3'd4;
  endfunction

  function automatic logic op_rot(
    input logic [2:0] op
  );
    return (op == OP_ROR) || (op == OP_ROL);
  endfunction

endpackage

// File: rtl/zad2lista4.sv
// 8-bit combinational shifter: logical/arithmetic right,
// logical left, rotate right/left by n.
module zad2lista4 (
  input  logic [7:0] i,
  input  logic [3:0] n,
  input  logic       ar,
  input  logic       lr,
  input  logic       rot,
  output logic [7:0] o
);

  logic [2:0]  s;
  logic [15:0] dbl;

  assign s = n[2:0];

  // Left modes only see n[2:0], so n=8 leaves i unchanged there.
  always_comb begin
    o   = i;
    dbl = '0;
    unique case ({rot, lr})
      2'b00: begin
        if (ar) o = 8'($signed(i) >>> n);
        else    o = i >> n;
      end
      2'b01: o = i << s;
      2'b10: begin
        dbl = {i, i} >> s;
        o   = dbl[7:0];
      end
      2'b11: begin
        dbl = {i, i} << s;
        o   = dbl[15:8];
      end
      default: o = i;
    endcase
  end

endmodule

// File: rtl/shift_seq_ctrl.sv
// Shift sequencer: accepts one command, iterates the shifter
// in chunks of at most MAX_STEP, then holds the result.
module shift_seq_ctrl
  import shift_pkg::*;
#(
  parameter int AMT_W    = DEF_AMT_W,
  parameter int MAX_STEP = DEF_MAX_STEP
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_data,
  input  logic [AMT_W-1:0] in_amt,
  input  logic [2:0]       in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       out_data,
  output logic             out_err,
  output logic             busy
);

  state_e           state_q, state_d;
  logic [7:0]       cur_q, cur_d;
  logic [AMT_W-1:0] rem_q, rem_d;
  logic [2:0]       op_q, op_d;
  logic             err_q, err_d;

  logic [2:0]       step;
  logic [7:0]       sh_o;
  logic             ar, lr, rot;

  assign step = (rem_q > AMT_W'(MAX_STEP))
              ? 3'(MAX_STEP) : rem_q[2:0];

  always_comb begin
    ar  = 1'b0;
    lr  = 1'b0;
    rot = 1'b0;
    case (op_q)
      OP_ASR: ar = 1'b1;
      OP_LSL: lr = 1'b1;
      OP_ROR: rot = 1'b1;
      OP_ROL: begin
        lr  = 1'b1;
        rot = 1'b1;
      end
      default: ;
    endcase
  end

  zad2lista4 u_sh (
    .i   (cur_q),
    .n   ({1'b0, step}),
    .ar  (ar),
    .lr  (lr),
    .rot (rot),
    .o   (sh_o)
  );

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q <= IDLE;
      cur_q   <= '0;
      rem_q   <= '0;
      op_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cur_q   <= cur_d;
      rem_q   <= rem_d;
      op_q    <= op_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cur_d   = cur_q;
    rem_d   = rem_q;
    op_d    = op_q;
    err_d   = err_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          cur_d = in_data;
          op_d  = in_op;
          err_d = !op_legal(in_op);
          // Rotations wrap every 8 bits, so only amt mod 8 matters.
          unique case (1'b1)
            !op_legal(in_op): rem_d = '0;
            op_rot(in_op):    rem_d = AMT_W'(in_amt[2:0]);
            default:          rem_d = in_amt;
          endcase
          state_d = (rem_d == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        cur_d = sh_o;
        rem_d = rem_q - AMT_W'(step);
        if (rem_d == '0) state_d = DONE;
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign out_data  = cur_q;
  assign out_err   = err_q && (state_q == DONE);
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Scoreboard bench for shift_seq_ctrl: directed commands
// with hand-computed results, checked by a separate monitor.
module tb_shift_seq_ctrl;
  import shift_pkg::*;

  logic       clk = 1'b0;
  logic       nrst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic [4:0] in_amt;
  logic [2:0] in_op;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic       out_err;
  logic       busy;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [7:0] d;
    logic       e;
    string      name;
  } exp_t;

  exp_t q[$];

  typedef struct packed {
    logic [7:0] d;
    logic [4:0] amt;
    logic [2:0] op;
    logic [7:0] ed;
    logic       ee;
  } vec_t;

  vec_t vecs [13] = '{
    '{8'hB4, 5'd3,  3'd0, 8'h16, 1'b0},
    '{8'h80, 5'd10, 3'd1, 8'hFF, 1'b0},
    '{8'h01, 5'd9,  3'd2, 8'h00, 1'b0},
    '{8'h81, 5'd17, 3'd4, 8'h03, 1'b0},
    '{8'h01, 5'd4,  3'd3, 8'h10, 1'b0},
    '{8'h5A, 5'd8,  3'd4, 8'h5A, 1'b0},
    '{8'hFF, 5'd31, 3'd0, 8'h00, 1'b0},
    '{8'h7F, 5'd31, 3'd1, 8'h00, 1'b0},
    '{8'h80, 5'd31, 3'd1, 8'hFF, 1'b0},
    '{8'hA5, 5'd0,  3'd0, 8'hA5, 1'b0},
    '{8'h01, 5'd7,  3'd3, 8'h02, 1'b0},
    '{8'hFF, 5'd7,  3'd2, 8'h80, 1'b0},
    '{8'hC0, 5'd5,  3'd1, 8'hFE, 1'b0}
  };

  shift_seq_ctrl dut (
    .clk       (clk),
    .nrst      (nrst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_amt    (in_amt),
    .in_op     (in_op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_err   (out_err),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(
    input string       nm,
    input logic [31:0] act,
    input logic [31:0] req
  );
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual %0h required %0h",
               nm, act, req);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (nrst && out_valid && out_ready) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_result actual %0h required none",
                 out_data);
      end else begin
        e = q.pop_front();
        chk({e.name, "_data"}, 32'(out_data), 32'(e.d));
        chk({e.name, "_err"}, 32'(out_err), 32'(e.e));
      end
    end
  end

  task automatic send(
    input string      nm,
    input logic [7:0] d,
    input logic [4:0] amt,
    input logic [2:0] op,
    input logic [7:0] ed,
    input logic       ee
  );
    exp_t e;
    bit   ok;
    ok       = 1'b0;
    in_data  = d;
    in_amt   = amt;
    in_op    = op;
    in_valid = 1'b1;
    for (int c = 0; c < 50; c++) begin
      if (in_ready) begin
        @(posedge clk);
        #1;
        ok = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    if (ok) begin
      e.d    = ed;
      e.e    = ee;
      e.name = nm;
      q.push_back(e);
    end else begin
      checks++;
      errors++;
      $display("FAIL %s_accept actual timeout required accept", nm);
    end
  endtask

  task automatic drain(input string nm);
    int c;
    c = 0;
    while (q.size() != 0 && c < 60) begin
      @(posedge clk);
      #1;
      c++;
    end
    if (q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL %s_drain actual timeout required result", nm);
      q.delete();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual timeout required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen;
    nrst      = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_amt    = '0;
    in_op     = '0;
    out_ready = 1'b1;
    #12;
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_in_ready", 32'(in_ready), 1);
    chk("rst_out_data", 32'(out_data), 0);
    chk("rst_out_err", 32'(out_err), 0);
    chk("rst_busy", 32'(busy), 0);
    #1 nrst = 1'b1;
    @(posedge clk);
    #1;

    // Reset in the middle of a long LSL; nothing may come out.
    in_data  = 8'h01;
    in_amt   = 5'd20;
    in_op    = OP_LSL;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk("run_busy", 32'(busy), 1);
    chk("run_in_ready", 32'(in_ready), 0);
    @(posedge clk);
    #1;
    nrst = 1'b0;
    #1;
    chk("midrst_out_valid", 32'(out_valid), 0);
    chk("midrst_in_ready", 32'(in_ready), 1);
    chk("midrst_out_data", 32'(out_data), 0);
    chk("midrst_busy", 32'(busy), 0);
    @(posedge clk);
    #1;
    nrst = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    chk("postrst_out_valid", 32'(out_valid), 0);

    for (int v = 0; v < 13; v++) begin
      send($sformatf("vec%0d", v), vecs[v].d, vecs[v].amt,
           vecs[v].op, vecs[v].ed, vecs[v].ee);
      drain($sformatf("vec%0d", v));
    end

    // Hold the result under backpressure with stray in_valid pulses.
    out_ready = 1'b0;
    send("bp", 8'hB4, 5'd3, OP_LSR, 8'h16, 1'b0);
    seen = 1'b0;
    for (int c = 0; c < 20; c++) begin
      if (out_valid) begin
        seen = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
    end
    chk("bp_valid_seen", 32'(seen), 1);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      chk($sformatf("bp_valid_%0d", c), 32'(out_valid), 1);
      chk($sformatf("bp_data_%0d", c), 32'(out_data), 32'h16);
      chk($sformatf("bp_in_ready_%0d", c), 32'(in_ready), 0);
      in_valid = ~in_valid;
      in_data  = 8'hEE;
      in_amt   = 5'd1;
      in_op    = OP_LSL;
    end
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("bp_release_in_ready", 32'(in_ready), 1);
    chk("bp_release_valid", 32'(out_valid), 0);
    chk("bp_queue_empty", 32'(q.size()), 0);
    send("after_bp", 8'h03, 5'd2, OP_LSL, 8'h0C, 1'b0);
    drain("after_bp");

    send("illegal", 8'h3C, 5'd5, 3'b110, 8'h3C, 1'b1);
    drain("illegal");
    send("legal_after", 8'h0F, 5'd2, OP_ROR, 8'hC3, 1'b0);
    drain("legal_after");

    repeat (4) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
